// File: rtl/tff_counter_bank.sv
// tff_counter_bank: a WIDTH-bit bank of T flip-flops wired as a synchronous
// modulo up/down counter. It has load, enable, a programmable modulus, a
// one-cycle terminal-count pulse and a saturating free-running cycle counter.
// Optional feature: define TFF_BANK_GRAY_EN to add a registered Gray-code
// output `gray` that tracks Q.
module tff_counter_bank #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic [WIDTH-1:0] mod_max,
    output logic [WIDTH-1:0] T,
    output logic [WIDTH-1:0] Q,
    output logic             tc,
`ifdef TFF_BANK_GRAY_EN
    output logic [WIDTH-1:0] gray,
`endif
    output logic [CNT_W-1:0] count
);

    localparam logic [WIDTH-1:0] ZERO_W  = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE_W   = WIDTH'(1'b1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1'b1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] qn_s;
    logic [WIDTH-1:0] t_s;
    logic             wrap_s;
    logic             tc_r;
    logic [CNT_W-1:0] count_r;

    // Next-state selection: load beats enable; the wrap flag marks a modulus roll-over.
    always_comb begin
        qn_s   = q_r;
        wrap_s = 1'b0;
        if (load) begin
            qn_s = load_val;
        end else if (!en) begin
            qn_s = q_r;
        end else if (up_dn) begin
            // Values above the modulus (possible after a load) also roll to zero.
            if (q_r >= mod_max) begin
                qn_s   = ZERO_W;
                wrap_s = 1'b1;
            end else begin
                qn_s = q_r + ONE_W;
            end
        end else begin
            if (q_r == ZERO_W) begin
                qn_s   = mod_max;
                wrap_s = 1'b1;
            end else begin
                qn_s = q_r - ONE_W;
            end
        end
    end

    // Toggle vector: the bits that must flip to reach the next state.
    always_comb begin
        t_s = q_r ^ qn_s;
    end

    // T flip-flop bank plus the registered terminal-count pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_r  <= ZERO_W;
            tc_r <= 1'b0;
        end else begin
            q_r  <= q_r ^ t_s;
            tc_r <= wrap_s;
        end
    end

    // Free-running cycle counter. It holds at all-ones instead of wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= {CNT_W{1'b0}};
        end else if (count_r != CNT_MAX) begin
            count_r <= count_r + CNT_ONE;
        end else begin
            count_r <= count_r;
        end
    end

`ifdef TFF_BANK_GRAY_EN
    logic [WIDTH-1:0] gray_r;

    // Gray code of the next state, registered so it moves with Q.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gray_r <= ZERO_W;
        end else begin
            gray_r <= qn_s ^ (qn_s >> 1'b1);
        end
    end

    assign gray = gray_r;
`endif

    assign T     = t_s;
    assign Q     = q_r;
    assign tc    = tc_r;
    assign count = count_r;

endmodule

// File: tb/tb_tff_counter_bank.sv
// Self-checking bench for tff_counter_bank. An arithmetic reference model of
// the counter is compared against the DUT on every falling edge. Directed
// literal checks pin down the sequences from the test plan. A second instance
// with a 4-bit cycle counter covers saturation.
module tb_tff_counter_bank;

    logic       clk      = 1'b0;
    logic       rst_n    = 1'b0;
    logic       en       = 1'b0;
    logic       up_dn    = 1'b1;
    logic       load     = 1'b0;
    logic [3:0] load_val = 4'd0;
    logic [3:0] mod_max  = 4'd15;

    logic [3:0]  T, Q, T4, Q4;
    logic        tc, tc4;
    logic [31:0] count;
    logic [3:0]  count4;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state.
    int     m_q    = 0;
    bit     m_tc   = 1'b0;
    longint m_cnt  = 0;
    int     m_cnt4 = 0;

    always #5 clk = ~clk;

    tff_counter_bank #(.WIDTH(4), .CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .up_dn(up_dn), .load(load),
        .load_val(load_val), .mod_max(mod_max),
        .T(T), .Q(Q), .tc(tc), .count(count)
    );

    tff_counter_bank #(.WIDTH(4), .CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .en(en), .up_dn(up_dn), .load(load),
        .load_val(load_val), .mod_max(mod_max),
        .T(T4), .Q(Q4), .tc(tc4), .count(count4)
    );

    function automatic int model_next(input int q, input bit ld, input int lv,
                                      input bit e, input bit ud, input int mm);
        if (ld) return lv;
        if (!e) return q;
        if (ud) return (q >= mm) ? 0 : q + 1;
        return (q == 0) ? mm : q - 1;
    endfunction

    function automatic bit model_wrap(input int q, input bit ld, input bit e,
                                      input bit ud, input int mm);
        if (ld || !e) return 1'b0;
        return ud ? (q >= mm) : (q == 0);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Reference model: advance on each clock edge, clear on async reset.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_q    <= 0;
            m_tc   <= 1'b0;
            m_cnt  <= 0;
            m_cnt4 <= 0;
        end else begin
            m_q    <= model_next(m_q, load, int'(load_val), en, up_dn, int'(mod_max));
            m_tc   <= model_wrap(m_q, load, en, up_dn, int'(mod_max));
            m_cnt  <= (m_cnt < 64'hFFFF_FFFF) ? m_cnt + 1 : m_cnt;
            m_cnt4 <= (m_cnt4 < 15) ? m_cnt4 + 1 : 15;
        end
    end

    // Compare every output against the model, away from the active edge.
    always @(negedge clk) begin
        check("model_Q",      64'(Q),      64'(m_q));
        check("model_tc",     64'(tc),     64'(m_tc));
        check("model_count",  64'(count),  64'(m_cnt));
        check("model_count4", 64'(count4), 64'(m_cnt4));
        check("model_T",      64'(T),
              64'((m_q ^ model_next(m_q, load, int'(load_val), en, up_dn, int'(mod_max))) & 15));
    end

    initial begin
        int seq2[6];
        int tc2[6];
        seq2 = '{2, 1, 0, 9, 8, 7};
        tc2  = '{0, 0, 0, 1, 0, 0};

        // Reset state.
        en = 1'b1; up_dn = 1'b1; mod_max = 4'd15;
        #1;
        check("rst_Q",     64'(Q),     64'd0);
        check("rst_tc",    64'(tc),    64'd0);
        check("rst_count", 64'(count), 64'd0);
        #11 rst_n = 1'b1;

        // Full up count, modulus 15.
        for (int i = 1; i <= 20; i++) begin
            tick(1);
            check("up_Q",     64'(Q),     64'(i % 16));
            check("up_tc",    64'(tc),    64'(i == 16));
            check("up_count", 64'(count), 64'(i));
            if (i == 15) check("up_T_at_15", 64'(T), 64'd15);
        end

        // Load 3, then count down with modulus 9.
        mod_max = 4'd9; up_dn = 1'b0; load = 1'b1; load_val = 4'd3; en = 1'b0;
        tick(1);
        check("ld_Q",  64'(Q),  64'd3);
        check("ld_tc", 64'(tc), 64'd0);
        load = 1'b0; en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick(1);
            check("dn_Q",  64'(Q),  64'(seq2[i]));
            check("dn_tc", 64'(tc), 64'(tc2[i]));
        end

        // Hold with enable low.
        en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick(1);
            check("hold_Q",  64'(Q),  64'd7);
            check("hold_T",  64'(T),  64'd0);
            check("hold_tc", 64'(tc), 64'd0);
        end
        check("hold_count", 64'(count), 64'd32);

        // Load above the modulus together with enable, then count up.
        mod_max = 4'd9; up_dn = 1'b1; load = 1'b1; load_val = 4'd12; en = 1'b1;
        tick(1);
        check("ldhi_Q",  64'(Q),  64'd12);
        check("ldhi_tc", 64'(tc), 64'd0);
        load = 1'b0;
        tick(1);
        check("ldhi_wrap_Q",  64'(Q),  64'd0);
        check("ldhi_wrap_tc", 64'(tc), 64'd1);
        tick(1);
        check("ldhi_next_Q",  64'(Q),  64'd1);
        check("ldhi_next_tc", 64'(tc), 64'd0);

        // Modulus zero: tc stays high while Q stays at zero.
        mod_max = 4'd0;
        for (int i = 0; i < 4; i++) begin
            tick(1);
            check("mod0_Q",  64'(Q),  64'd0);
            check("mod0_tc", 64'(tc), 64'd1);
        end

        // Asynchronous reset between edges at Q=7.
        mod_max = 4'd15;
        tick(7);
        check("pre_rst_Q", 64'(Q), 64'd7);
        #2 rst_n = 1'b0;
        #1;
        check("arst_Q",      64'(Q),      64'd0);
        check("arst_tc",     64'(tc),     64'd0);
        check("arst_count",  64'(count),  64'd0);
        check("arst_count4", 64'(count4), 64'd0);
        #1 rst_n = 1'b1;
        tick(1);
        check("post_rst_Q",     64'(Q),     64'd1);
        check("post_rst_count", 64'(count), 64'd1);
        tick(6);
        check("cnt4_below_8", 64'(count4 >= 4'd8), 64'd0);
        tick(1);
        check("cnt4_reach_8", 64'(count4 >= 4'd8), 64'd1);
        tick(12);
        check("cnt4_sat",   64'(count4), 64'd15);
        check("cnt32_at20", 64'(count),  64'd20);

        // Randomized phase, checked by the model on every falling edge.
        for (int i = 0; i < 600; i++) begin
            en       = ($urandom_range(0, 3) != 0);
            up_dn    = $urandom_range(0, 1) == 1;
            load     = ($urandom_range(0, 9) == 0);
            load_val = 4'($urandom_range(0, 15));
            mod_max  = ($urandom_range(0, 3) == 0) ? 4'd15 : 4'($urandom_range(0, 15));
            if ($urandom_range(0, 99) == 0) begin
                #2 rst_n = 1'b0;
                #1 rst_n = 1'b1;
            end
            tick(1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
